// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: registered Rijndael ShiftRows stage with a 2-entry skid buffer.
// Define SHIFT_ROWS_INV_EN to build per-beat inverse shifting (in_inv).
module shift_rows_pipe #(
   parameter  int NB         = 4,
   parameter  int TAG_WIDTH  = 4,
   localparam int DATA_WIDTH = 32 * NB
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_inv,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [TAG_WIDTH-1:0]  out_tag,
   output logic [1:0]            occupancy
);

   if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
   end

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [TAG_WIDTH-1:0]  tag;
   } beat_t;

   logic [DATA_WIDTH-1:0] fwd_data;
   logic [DATA_WIDTH-1:0] shifted;
   beat_t                 new_beat;
   beat_t                 o_beat;
   beat_t                 s_beat;
   logic                  o_valid;
   logic                  s_valid;
   logic                  accept;
   logic                  pop;

   // Pure wiring: each output byte picks a fixed source byte of its row.
   for (genvar c = 0; c < NB; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         localparam int K   = 4 * c + r;
         localparam int OFF = (NB == 8 && r >= 2) ? r + 1 : r;
         localparam int FC  = (c + OFF) % NB;
         localparam int FK  = 4 * FC + r;
         assign fwd_data[DATA_WIDTH-1-8*K -: 8] =
            in_data[DATA_WIDTH-1-8*FK -: 8];
      end
   end

`ifdef SHIFT_ROWS_INV_EN
   logic [DATA_WIDTH-1:0] inv_data;

   for (genvar c = 0; c < NB; c++) begin : g_icol
      for (genvar r = 0; r < 4; r++) begin : g_irow
         localparam int K   = 4 * c + r;
         localparam int OFF = (NB == 8 && r >= 2) ? r + 1 : r;
         localparam int IC  = (c - OFF + NB) % NB;
         localparam int IK  = 4 * IC + r;
         assign inv_data[DATA_WIDTH-1-8*K -: 8] =
            in_data[DATA_WIDTH-1-8*IK -: 8];
      end
   end

   assign shifted = in_inv ? inv_data : fwd_data;
`else
   logic unused_inv;

   assign unused_inv = in_inv;
   assign shifted    = fwd_data;
`endif

   assign new_beat.data = shifted;
   assign new_beat.tag  = in_tag;

   assign in_ready  = ~s_valid;
   assign accept    = in_valid & ~s_valid;
   assign pop       = o_valid & out_ready;
   assign out_valid = o_valid;
   assign out_data  = o_beat.data;
   assign out_tag   = o_beat.tag;
   assign occupancy = {1'b0, o_valid} + {1'b0, s_valid};

   // O drains from S first so beats leave in arrival order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_valid <= 1'b0;
         s_valid <= 1'b0;
         o_beat  <= '0;
         s_beat  <= '0;
      end else if (!o_valid || pop) begin
         if (s_valid) begin
            o_beat  <= s_beat;
            o_valid <= 1'b1;
            s_valid <= 1'b0;
         end else if (accept) begin
            o_beat  <= new_beat;
            o_valid <= 1'b1;
         end else begin
            o_valid <= 1'b0;
         end
      end else if (accept) begin
         s_beat  <= new_beat;
         s_valid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb_shift_rows_pipe: self-checking bench for shift_rows_pipe (NB=4 and NB=8).
// Randomized traffic is scored against a row/column ShiftRows model.
module tb_shift_rows_pipe;

   logic         clk = 1'b0;
   logic         rst_n;

   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         in_inv;
   logic [3:0]   in_tag;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic [3:0]   out_tag;
   logic [1:0]   occupancy;

   logic         v8_in_valid;
   logic         v8_in_ready;
   logic [255:0] v8_in_data;
   logic         v8_in_inv;
   logic [3:0]   v8_in_tag;
   logic         v8_out_valid;
   logic         v8_out_ready;
   logic [255:0] v8_out_data;
   logic [3:0]   v8_out_tag;
   logic [1:0]   v8_occupancy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   shift_rows_pipe #(.NB(4), .TAG_WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_inv(in_inv), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag),
      .occupancy(occupancy)
   );

   shift_rows_pipe #(.NB(8), .TAG_WIDTH(4)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(v8_in_valid), .in_ready(v8_in_ready),
      .in_data(v8_in_data), .in_inv(v8_in_inv), .in_tag(v8_in_tag),
      .out_valid(v8_out_valid), .out_ready(v8_out_ready),
      .out_data(v8_out_data), .out_tag(v8_out_tag),
      .occupancy(v8_occupancy)
   );

   // Model: state as a 4 x nb byte matrix, rows rotated by their offsets.
   function automatic logic [255:0] ref_shift(input logic [255:0] d,
                                              input int nb, input bit inv);
      logic [7:0]   st [4][8];
      logic [255:0] res;
      int           offs [4];
      int           src;
      res = '0;
      offs[0] = 0;
      offs[1] = 1;
      offs[2] = (nb == 8) ? 3 : 2;
      offs[3] = (nb == 8) ? 4 : 3;
      for (int k = 0; k < 4 * nb; k++)
         st[k % 4][k / 4] = d[8 * (4 * nb - 1 - k) +: 8];
      for (int c = 0; c < nb; c++) begin
         for (int r = 0; r < 4; r++) begin
            src = inv ? (c - offs[r] + nb) % nb : (c + offs[r]) % nb;
            res[8 * (4 * nb - 1 - (4 * c + r)) +: 8] = st[r][src];
         end
      end
      return res;
   endfunction

   function automatic bit eff_inv(input bit inv);
`ifdef SHIFT_ROWS_INV_EN
      return inv;
`else
      return 1'b0 & inv;
`endif
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_out_valid got %b want 0", out_valid);
      end
      n_checks++;
      if (occupancy !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_occupancy got %0d want 0", occupancy);
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready got %b want 1", in_ready);
      end
      n_checks++;
      if (out_data !== 128'd0 || out_tag !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_out_data got %h/%h want 0/0", out_data, out_tag);
      end
   endtask

   task automatic test_fwd_vector();
      logic [127:0] exp;
      exp = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_inv    = 1'b0;
      in_tag    = 4'd3;
      in_data   = 128'hd42711aee0bf98f1b8b45de51e415230;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
         n_fail++;
         $display("FAIL fwd_vector got %b/%h want 1/%h", out_valid, out_data, exp);
      end
      n_checks++;
      if (out_tag !== 4'd3 || occupancy !== 2'd1) begin
         n_fail++;
         $display("FAIL fwd_vector_tag got %0d occ %0d want 3 occ 1", out_tag, occupancy);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
         n_fail++;
         $display("FAIL fwd_drain got %b occ %0d want 0 occ 0", out_valid, occupancy);
      end
   endtask

   task automatic test_inverse();
      logic [127:0] d;
      logic [127:0] exp;
      d = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
`ifdef SHIFT_ROWS_INV_EN
      exp = 128'hd42711aee0bf98f1b8b45de51e415230;
`else
      exp = ref_shift({128'd0, d}, 4, 1'b0);
`endif
      in_valid = 1'b1;
      in_inv   = 1'b1;
      in_tag   = 4'd9;
      in_data  = d;
      tick();
      in_valid = 1'b0;
      in_inv   = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp || out_tag !== 4'd9) begin
         n_fail++;
         $display("FAIL inverse got %b/%h/%0d want 1/%h/9", out_valid, out_data, out_tag, exp);
      end
      tick();
   endtask

   task automatic test_nb8();
      logic [255:0] exp;
      for (int k = 0; k < 32; k++)
         v8_in_data[8 * (31 - k) +: 8] = 8'(k);
      exp = ref_shift(v8_in_data, 8, 1'b0);
      v8_out_ready = 1'b1;
      v8_in_valid  = 1'b1;
      v8_in_tag    = 4'd5;
      tick();
      v8_in_valid = 1'b0;
      n_checks++;
      if (v8_out_valid !== 1'b1 || v8_out_data[255:192] !== 64'h00050e1304091217) begin
         n_fail++;
         $display("FAIL nb8_head got %b/%h want 1/00050e1304091217", v8_out_valid, v8_out_data[255:192]);
      end
      n_checks++;
      if (v8_out_data !== exp || v8_out_tag !== 4'd5) begin
         n_fail++;
         $display("FAIL nb8_full got %h want %h", v8_out_data, exp);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [127:0] a, b, c;
      a = rand128();
      b = rand128();
      c = rand128();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = a;
      in_tag    = 4'd1;
      tick();
      in_data = b;
      in_tag  = 4'd2;
      tick();
      n_checks++;
      if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_full got occ %0d rdy %b want occ 2 rdy 0", occupancy, in_ready);
      end
      in_data = c;
      in_tag  = 4'd3;
      tick();
      n_checks++;
      if (occupancy !== 2'd2 || out_data !== ref_shift({128'd0, a}, 4, 0)
          || out_tag !== 4'd1) begin
         n_fail++;
         $display("FAIL b2b_hold got occ %0d %h/%0d want occ 2 A/1", occupancy, out_data, out_tag);
      end
      out_ready = 1'b1;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== ref_shift({128'd0, b}, 4, 0)
          || out_tag !== 4'd2 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_second got %b/%h/%0d rdy %b want 1/B/2 rdy 1", out_valid, out_data, out_tag, in_ready);
      end
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== ref_shift({128'd0, c}, 4, 0)
          || out_tag !== 4'd3 || occupancy !== 2'd1) begin
         n_fail++;
         $display("FAIL b2b_third got %b/%h/%0d occ %0d want 1/C/3 occ 1", out_valid, out_data, out_tag, occupancy);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_empty got %b want 0", out_valid);
      end
   endtask

   task automatic test_streaming();
      logic [127:0] exp_q [$];
      logic [3:0]   tag_q [$];
      logic [127:0] e_d;
      logic [3:0]   e_t;
      int           sent;
      int           got;
      int           cyc;
      bit           acc;
      bit           pp;
      logic         rdy_seen;
      sent = 0;
      got  = 0;
      cyc  = 0;
      in_valid = 1'b0;
      while (got < 100 && cyc < 3000) begin
         if (!in_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            in_data  = rand128();
            in_inv   = 1'($urandom_range(0, 1));
            in_tag   = 4'($urandom);
         end
         out_ready = ($urandom_range(0, 2) != 0);
         acc = in_valid && in_ready;
         pp  = out_valid && out_ready;
         rdy_seen = in_ready;
         if (pp) begin
            e_d = exp_q.pop_front();
            e_t = tag_q.pop_front();
            got++;
            n_checks++;
            if (out_data !== e_d || out_tag !== e_t) begin
               n_fail++;
               $display("FAIL stream_beat%0d got %h/%0d want %h/%0d", got, out_data, out_tag, e_d, e_t);
            end
         end
         if (acc) begin
            exp_q.push_back(ref_shift({128'd0, in_data}, 4, eff_inv(in_inv)));
            tag_q.push_back(in_tag);
            sent++;
         end
         @(negedge clk);
         n_checks++;
         if (in_ready !== rdy_seen) begin
            n_fail++;
            $display("FAIL stream_ready_midcycle got %b want %b", in_ready, rdy_seen);
         end
         tick();
         if (acc) begin
            in_valid = 1'b0;
            in_inv   = 1'b0;
         end
         n_checks++;
         if (occupancy !== 2'(exp_q.size()) || in_ready !== (exp_q.size() < 2)) begin
            n_fail++;
            $display("FAIL stream_occupancy got %0d rdy %b want %0d", occupancy, in_ready, exp_q.size());
         end
         cyc++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (got != 100) begin
         n_fail++;
         $display("FAIL stream_timeout got %0d beats want 100", got);
      end
   endtask

   task automatic test_reset_mid();
      logic [127:0] d;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = rand128();
      in_tag    = 4'd4;
      tick();
      in_data = rand128();
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (occupancy !== 2'd2) begin
         n_fail++;
         $display("FAIL rstmid_prefill got %0d want 2", occupancy);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_async got %b occ %0d rdy %b want 0 occ 0 rdy 1", out_valid, occupancy, in_ready);
      end
      n_checks++;
      if (out_data !== 128'd0 || out_tag !== 4'd0) begin
         n_fail++;
         $display("FAIL rstmid_data got %h/%0d want 0/0", out_data, out_tag);
      end
      tick();
      rst_n = 1'b1;
      tick();
      d = rand128();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = d;
      in_tag    = 4'd7;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== ref_shift({128'd0, d}, 4, 0)
          || out_tag !== 4'd7) begin
         n_fail++;
         $display("FAIL rstmid_first got %b/%h/%0d want 1/%h/7", out_valid, out_data, out_tag,
                  ref_shift({128'd0, d}, 4, 0));
      end
      tick();
   endtask

   initial begin
      rst_n        = 1'b0;
      in_valid     = 1'b0;
      in_data      = '0;
      in_inv       = 1'b0;
      in_tag       = '0;
      out_ready    = 1'b0;
      v8_in_valid  = 1'b0;
      v8_in_data   = '0;
      v8_in_inv    = 1'b0;
      v8_in_tag    = '0;
      v8_out_ready = 1'b0;
      repeat (3) tick();
      test_reset();
      rst_n = 1'b1;
      tick();
      test_fwd_vector();
      test_inverse();
      test_nb8();
      test_back_to_back();
      test_streaming();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
